fft_frame_loader: RTL and testbench

Deserialising input stage of the FFT datapath. Accepts one sample per cycle over a valid/ready stream, writes each sample into a frame slot selected by a rotating one-hot pointer, and presents the completed LENGTH-point frame in parallel to the downstream butterfly stage over a second valid/ready handshake. The one-hot pointer is exported, so the slot-select sequencing stays visible alongside the block's other signals.

---
 rtl/fft_frame_loader_if.sv | 24 ++
 rtl/fft_frame_loader.sv | 69 ++++++
 tb/tb_fft_frame_loader.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/fft_frame_loader_if.sv
// Stream bundle for fft_frame_loader: sample input handshake, parallel frame output handshake
// and the exported one-hot slot pointer. The loader connects to the slave modport.
interface fft_frame_loader_if #(
  parameter int LENGTH = 4,
  parameter int DATA_W = 16
);
  logic                     in_valid;
  logic                     in_ready;
  logic [DATA_W-1:0]        in_data;
  logic                     frame_valid;
  logic                     frame_ready;
  logic [LENGTH*DATA_W-1:0] frame_data;
  logic [LENGTH-1:0]        slot;

  modport master (
    output in_valid, in_data, frame_ready,
    input  in_ready, frame_valid, frame_data, slot
  );

  modport slave (
    input  in_valid, in_data, frame_ready,
    output in_ready, frame_valid, frame_data, slot
  );
endinterface

// File: rtl/fft_frame_loader.sv
// Deserialises a sample stream into LENGTH-point frames for the FFT butterfly stage.
// Define FFT_FRAME_LOADER_BITREV_EN to store samples in bit-reversed slot order.
module fft_frame_loader #(
  parameter int LENGTH = 4,
  parameter int DATA_W = 16
) (
  input logic               clk,
  input logic               rst,
  fft_frame_loader_if.slave bus
);
  localparam int CW = (LENGTH > 1) ? $clog2(LENGTH) : 1;

  localparam logic [0:0] FILL = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic [0:0]               state;
  logic [CW-1:0]            cnt;
  logic [CW-1:0]            idx;
  logic [LENGTH-1:0]        onehot;
  logic [LENGTH*DATA_W-1:0] frame_q;

  function automatic logic [CW-1:0] map_idx(input logic [CW-1:0] c);
    logic [CW-1:0] r;
`ifdef FFT_FRAME_LOADER_BITREV_EN
    for (int b = 0; b < CW; b++) begin
      r[b] = c[CW-1-b];
    end
`else
    r = c;
`endif
    return r;
  endfunction

  always_comb begin
    idx         = map_idx(cnt);
    onehot      = '0;
    onehot[idx] = 1'b1;
  end

  assign bus.slot        = onehot;
  assign bus.in_ready    = (state == FILL);
  assign bus.frame_valid = (state == HOLD);
  assign bus.frame_data  = frame_q;

  // Frame slots are only rewritten by the next fill, so HOLD keeps them stable without extra enables.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= FILL;
      cnt     <= '0;
      frame_q <= '0;
    end else begin
      case (state)
        FILL: begin
          if (bus.in_valid) begin
            for (int k = 0; k < LENGTH; k++) begin
              if (onehot[k]) frame_q[k*DATA_W +: DATA_W] <= bus.in_data;
            end
            cnt <= cnt + CW'(1);
            if (cnt == CW'(LENGTH-1)) state <= HOLD;
          end
        end
        HOLD: begin
          if (bus.frame_ready) state <= FILL;
        end
        default: state <= FILL;
      endcase
    end
  end
endmodule

// File: tb/tb_fft_frame_loader.sv
// Directed self-checking bench for fft_frame_loader (LENGTH=4, DATA_W=16).
// Expected slot order and frames follow FFT_FRAME_LOADER_BITREV_EN when it is defined.
module tb_fft_frame_loader;
  localparam int LENGTH = 4;
  localparam int DATA_W = 16;

  logic clk = 1'b0;
  logic rst;
  int   compared   = 0;
  int   mismatched = 0;

  fft_frame_loader_if #(.LENGTH(LENGTH), .DATA_W(DATA_W)) bus ();

  fft_frame_loader #(.LENGTH(LENGTH), .DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

`ifdef FFT_FRAME_LOADER_BITREV_EN
  localparam logic [63:0] EXP_FRAME = 64'h0044_0022_0033_0011;
  int order [4] = '{0, 2, 1, 3};
`else
  localparam logic [63:0] EXP_FRAME = 64'h0044_0033_0022_0011;
  int order [4] = '{0, 1, 2, 3};
`endif

  logic [15:0] samples [4] = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [15:0] d, input logic fr);
    bus.in_valid    = v;
    bus.in_data     = d;
    bus.frame_ready = fr;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] slotOf(input int i);
    logic [3:0] s;
    s = 4'b0000;
    s[order[i]] = 1'b1;
    return s;
  endfunction

  // Drives four back-to-back samples, checking the slot pointer before each accept.
  task automatic fillBackToBack(input string tag);
    for (int i = 0; i < 4; i++) begin
      checkOutput({tag, "_slot"}, 64'(bus.slot), 64'(slotOf(i)));
      applyStimulus(1'b1, samples[i], 1'b0);
      tick();
    end
    applyStimulus(1'b0, 16'h0000, 1'b0);
  endtask

  task automatic handoff(input string tag);
    applyStimulus(1'b0, 16'h0000, 1'b1);
    checkOutput({tag, "_handoff_in_ready"}, 64'(bus.in_ready), 64'd0);
    tick();
    applyStimulus(1'b0, 16'h0000, 1'b0);
    checkOutput({tag, "_after_in_ready"}, 64'(bus.in_ready), 64'd1);
    checkOutput({tag, "_after_frame_valid"}, 64'(bus.frame_valid), 64'd0);
  endtask

  logic [63:0] expf;
  int          n;

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 16'h0000, 1'b0);
    repeat (3) tick();
    rst = 1'b0;
    checkOutput("reset_in_ready", 64'(bus.in_ready), 64'd1);
    checkOutput("reset_frame_valid", 64'(bus.frame_valid), 64'd0);
    checkOutput("reset_frame_data", bus.frame_data, 64'd0);
    checkOutput("reset_slot", 64'(bus.slot), 64'b0001);

    fillBackToBack("b2b");
    checkOutput("b2b_frame_valid", 64'(bus.frame_valid), 64'd1);
    checkOutput("b2b_in_ready", 64'(bus.in_ready), 64'd0);
    checkOutput("b2b_frame_data", bus.frame_data, EXP_FRAME);
    checkOutput("b2b_slot_wrap", 64'(bus.slot), 64'b0001);

    // Backpressure with junk offered on the input, which must be ignored.
    for (int c = 0; c < 5; c++) begin
      applyStimulus(1'b1, 16'hDEAD, 1'b0);
      tick();
      checkOutput("bp_frame_valid", 64'(bus.frame_valid), 64'd1);
      checkOutput("bp_in_ready", 64'(bus.in_ready), 64'd0);
      checkOutput("bp_frame_data", bus.frame_data, EXP_FRAME);
    end
    handoff("bp");

    for (int i = 0; i < 4; i++) begin
      checkOutput("gap_slot", 64'(bus.slot), 64'(slotOf(i)));
      applyStimulus(1'b1, samples[i], 1'b0);
      tick();
      if (i < 3) begin
        applyStimulus(1'b0, 16'hBEEF, 1'b0);
        checkOutput("gap_frame_valid_low", 64'(bus.frame_valid), 64'd0);
        tick();
        tick();
      end
    end
    applyStimulus(1'b0, 16'h0000, 1'b0);
    checkOutput("gap_frame_valid", 64'(bus.frame_valid), 64'd1);
    checkOutput("gap_frame_data", bus.frame_data, EXP_FRAME);
    handoff("gap");

    applyStimulus(1'b1, 16'h00AA, 1'b0);
    tick();
    applyStimulus(1'b1, 16'h00BB, 1'b0);
    tick();
    applyStimulus(1'b0, 16'h0000, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("midrst_slot", 64'(bus.slot), 64'b0001);
    checkOutput("midrst_frame_data", bus.frame_data, 64'd0);
    checkOutput("midrst_in_ready", 64'(bus.in_ready), 64'd1);
    fillBackToBack("midrst");
    checkOutput("midrst_frame_valid", 64'(bus.frame_valid), 64'd1);
    checkOutput("midrst_result", bus.frame_data, EXP_FRAME);
    handoff("midrst");

    // Continuous stream: accepts in cycles 0..3 of each 5-cycle period, frame shown in cycle 4.
    n = 0;
    for (int t = 0; t < 15; t++) begin
      checkOutput("cont_in_ready", 64'(bus.in_ready), 64'((t % 5) != 4));
      checkOutput("cont_frame_valid", 64'(bus.frame_valid), 64'((t % 5) == 4));
      if ((t % 5) == 4) begin
        expf = '0;
        for (int i = 0; i < 4; i++) begin
          expf[order[i]*16 +: 16] = 16'h1000 + 16'((t / 5) * 4 + i);
        end
        checkOutput("cont_frame_data", bus.frame_data, expf);
      end
      applyStimulus(1'b1, 16'h1000 + 16'(n), 1'b1);
      if ((t % 5) != 4) n++;
      tick();
    end
    applyStimulus(1'b0, 16'h0000, 1'b0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
